// File: rtl/dma_register_file_pkg.sv
// Shared definitions for the 8237A program-mode register file: register
// address codes, the mode register layout, status bit positions and the
// byte-merge helper used by the per-channel address/count registers.
package dma_register_file_pkg;

    // Register address codes (CPU view, 4-bit address space).
    // Codes 0..7 are channel registers: addr[2:1] = channel, addr[0] = count.
    localparam logic [3:0] ADDR_CMD_STATUS   = 4'd8;   // write command / read status
    localparam logic [3:0] ADDR_REQUEST      = 4'd9;
    localparam logic [3:0] ADDR_SINGLE_MASK  = 4'd10;
    localparam logic [3:0] ADDR_MODE         = 4'd11;
    localparam logic [3:0] ADDR_CLEAR_BPFF   = 4'd12;
    localparam logic [3:0] ADDR_MASTER_CLEAR = 4'd13;  // write master clear / read temp
    localparam logic [3:0] ADDR_CLEAR_MASK   = 4'd14;
    localparam logic [3:0] ADDR_WRITE_MASK   = 4'd15;

    // Mode register bits 7:2 as stored per channel.
    typedef struct packed {
        logic [1:0] transfer_mode;
        logic       addr_dec;
        logic       autoinit;
        logic [1:0] xfer_type;
    } mode_t;

    // Status register layout: {request[3:0], terminal_count[3:0]}.
    localparam int STATUS_TC_LSB  = 0;
    localparam int STATUS_REQ_LSB = 4;

    // Replace one byte of a 16-bit register; hi selects the upper byte.
    function automatic logic [15:0] merge_byte(input logic [15:0] word,
                                               input logic        hi,
                                               input logic [7:0]  b);
        logic [15:0] result;
        if (hi) begin
            result = {b, word[7:0]};
        end else begin
            result = {word[15:8], b};
        end
        return result;
    endfunction

endpackage

// File: rtl/dma_register_file_channel_regs.sv
// Base/current address and word-count registers of one DMA channel.
// CPU byte writes land in both base and current; an engine update in the
// same cycle overrides the current value (autoinit reloads from base).
module dma_channel_regs
    import dma_register_file_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic          wr_sel_count,
    input  logic          wr_hi,
    input  logic [7:0]    wr_data,
    input  logic          upd_valid,
    input  logic [AW-1:0] upd_addr,
    input  logic [AW-1:0] upd_count,
    input  logic          upd_tc,
    input  logic          autoinit,
    output logic [AW-1:0] base_addr,
    output logic [AW-1:0] base_count,
    output logic [AW-1:0] cur_addr,
    output logic [AW-1:0] cur_count
);

    // Byte writes from the CPU, then engine update / autoinit reload on top.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_addr  <= {AW{1'b0}};
            base_count <= {AW{1'b0}};
            cur_addr   <= {AW{1'b0}};
            cur_count  <= {AW{1'b0}};
        end else begin
            if (wr_en) begin
                if (wr_sel_count) begin
                    base_count <= merge_byte(base_count, wr_hi, wr_data);
                    cur_count  <= merge_byte(cur_count, wr_hi, wr_data);
                end else begin
                    base_addr  <= merge_byte(base_addr, wr_hi, wr_data);
                    cur_addr   <= merge_byte(cur_addr, wr_hi, wr_data);
                end
            end
            if (upd_valid) begin
                if (upd_tc && autoinit) begin
                    cur_addr  <= base_addr;
                    cur_count <= base_count;
                end else begin
                    cur_addr  <= upd_addr;
                    cur_count <= upd_count;
                end
            end
        end
    end

endmodule

// File: rtl/dma_register_file.sv
// 8237A program-mode register file: CPU access decode, byte pointer
// flip-flop, command/mode/mask/request/status/temp registers, and the
// four channel address/count register sets.
module dma_register_file
    import dma_register_file_pkg::*;
#(
    parameter int NCH = 4,
    parameter int AW  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cs_n,
    input  logic                    ior_n,
    input  logic                    iow_n,
    input  logic [3:0]              addr,
    input  logic [7:0]              data_in,
    output logic [7:0]              data_out,
    output logic                    data_oe,
    input  logic                    hlda,
    input  logic [NCH-1:0]          dreq,
    input  logic                    upd_valid,
    input  logic [1:0]              upd_ch,
    input  logic [AW-1:0]           upd_addr,
    input  logic [AW-1:0]           upd_count,
    input  logic                    upd_tc,
    input  logic                    temp_load,
    input  logic [7:0]              temp_in,
    output logic [NCH-1:0][AW-1:0]  cur_addr,
    output logic [NCH-1:0][AW-1:0]  cur_count,
    output logic [NCH-1:0][AW-1:0]  base_addr,
    output logic [NCH-1:0][AW-1:0]  base_count,
    output logic [NCH-1:0][5:0]     mode,
    output logic [7:0]              command,
    output logic [NCH-1:0]          mask,
    output logic [NCH-1:0]          sw_req
);

    logic                cpu_rd_s;
    logic                active_s;
    logic                acc_start_s;
    logic                acc_end_s;
    logic                wr_start_s;
    logic                active_r;
    logic                acc_chan_r;       // current access targets a channel register
    logic                acc_status_rd_r;  // current access is a status read
    logic                bpff_r;
    mode_t [NCH-1:0]     mode_r;
    logic [7:0]          command_r;
    logic [NCH-1:0]      mask_r;
    logic [NCH-1:0]      sw_req_r;
    logic [NCH-1:0]      tc_latch_r;
    logic [7:0]          temp_r;
    logic [7:0]          status_s;
    logic [AW-1:0]       rd_word_s;
    logic [7:0]          rd_data_s;

    assign cpu_rd_s    = ~cs_n & ~hlda & ~ior_n & iow_n;
    assign active_s    = ~cs_n & ~hlda & (ior_n ^ iow_n);
    assign acc_start_s = active_s & ~active_r;
    assign acc_end_s   = ~active_s & active_r;
    assign wr_start_s  = acc_start_s & ~iow_n;

    // Access tracking; reset parks active_r high so a strobe still low after
    // reset must rise before a new access can start.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_r        <= 1'b1;
            acc_chan_r      <= 1'b0;
            acc_status_rd_r <= 1'b0;
        end else begin
            active_r <= active_s;
            if (acc_start_s) begin
                acc_chan_r      <= (addr[3] == 1'b0);
                acc_status_rd_r <= ~ior_n & (addr == ADDR_CMD_STATUS);
            end else if (acc_end_s) begin
                acc_chan_r      <= 1'b0;
                acc_status_rd_r <= 1'b0;
            end
        end
    end

    // Control registers: CPU writes first, engine terminal-count effects last
    // so they win over a coincident CPU write or status-read clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            bpff_r     <= 1'b0;
            mode_r     <= {(NCH*6){1'b0}};
            command_r  <= 8'h00;
            mask_r     <= {NCH{1'b1}};
            sw_req_r   <= {NCH{1'b0}};
            tc_latch_r <= {NCH{1'b0}};
            temp_r     <= 8'h00;
        end else begin
            if (temp_load) begin
                temp_r <= temp_in;
            end
            if (wr_start_s) begin
                case (addr)
                    ADDR_CMD_STATUS:   command_r <= data_in;
                    ADDR_REQUEST:      sw_req_r[data_in[1:0]] <= data_in[2];
                    ADDR_SINGLE_MASK:  mask_r[data_in[1:0]] <= data_in[2];
                    ADDR_MODE:         mode_r[data_in[1:0]] <= mode_t'(data_in[7:2]);
                    ADDR_CLEAR_BPFF:   bpff_r <= 1'b0;
                    ADDR_MASTER_CLEAR: begin
                        command_r  <= 8'h00;
                        sw_req_r   <= {NCH{1'b0}};
                        tc_latch_r <= {NCH{1'b0}};
                        temp_r     <= 8'h00;
                        bpff_r     <= 1'b0;
                        mask_r     <= {NCH{1'b1}};
                    end
                    ADDR_CLEAR_MASK:   mask_r <= {NCH{1'b0}};
                    ADDR_WRITE_MASK:   mask_r <= data_in[3:0];
                    default: begin
                    end
                endcase
            end
            if (acc_end_s && acc_chan_r) begin
                bpff_r <= ~bpff_r;
            end
            if (acc_end_s && acc_status_rd_r) begin
                tc_latch_r <= {NCH{1'b0}};
            end
            if (upd_valid && upd_tc) begin
                tc_latch_r[upd_ch] <= 1'b1;
                sw_req_r[upd_ch]   <= 1'b0;
                if (!mode_r[upd_ch].autoinit) begin
                    mask_r[upd_ch] <= 1'b1;
                end
            end
        end
    end

    // Status byte assembly.
    always_comb begin
        status_s = 8'h00;
        status_s[STATUS_REQ_LSB +: 4] = dreq | sw_req_r;
        status_s[STATUS_TC_LSB +: 4]  = tc_latch_r;
    end

    // Read data mux, selected by address and byte pointer.
    always_comb begin
        rd_word_s = {AW{1'b0}};
        rd_data_s = 8'h00;
        if (addr[3] == 1'b0) begin
            rd_word_s = addr[0] ? cur_count[addr[2:1]] : cur_addr[addr[2:1]];
            rd_data_s = bpff_r ? rd_word_s[15:8] : rd_word_s[7:0];
        end else begin
            case (addr)
                ADDR_CMD_STATUS:   rd_data_s = status_s;
                ADDR_MASTER_CLEAR: rd_data_s = temp_r;
                default:           rd_data_s = 8'h00;
            endcase
        end
    end

    assign data_oe  = cpu_rd_s & ~reset;
    assign data_out = (cpu_rd_s & ~reset) ? rd_data_s : 8'h00;

    assign command = command_r;
    assign mask    = mask_r;
    assign sw_req  = sw_req_r;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign mode[g] = mode_r[g];

        dma_channel_regs #(.AW(AW)) u_regs (
            .clk          (clk),
            .reset        (reset),
            .wr_en        (wr_start_s & (addr[3] == 1'b0) & (addr[2:1] == 2'(g))),
            .wr_sel_count (addr[0]),
            .wr_hi        (bpff_r),
            .wr_data      (data_in),
            .upd_valid    (upd_valid & (upd_ch == 2'(g))),
            .upd_addr     (upd_addr),
            .upd_count    (upd_count),
            .upd_tc       (upd_tc),
            .autoinit     (mode_r[g].autoinit),
            .base_addr    (base_addr[g]),
            .base_count   (base_count[g]),
            .cur_addr     (cur_addr[g]),
            .cur_count    (cur_count[g])
        );
    end

endmodule

// File: tb/tb_dma_register_file.sv
// Self-checking bench for dma_register_file: directed scenarios followed by
// randomized CPU/engine traffic compared against a register-level model.
module tb_dma_register_file;

    logic              clk = 1'b0;
    logic              reset, cs_n, ior_n, iow_n, hlda;
    logic [3:0]        addr;
    logic [7:0]        data_in, data_out, temp_in;
    logic              data_oe, upd_valid, upd_tc, temp_load;
    logic [3:0]        dreq, mask, sw_req;
    logic [1:0]        upd_ch;
    logic [15:0]       upd_addr, upd_count;
    logic [3:0][15:0]  cur_addr, cur_count, base_addr, base_count;
    logic [3:0][5:0]   mode;
    logic [7:0]        command;

    always #5 clk = ~clk;

    dma_register_file #(.NCH(4), .AW(16)) dut (
        .clk(clk), .reset(reset), .cs_n(cs_n), .ior_n(ior_n), .iow_n(iow_n),
        .addr(addr), .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
        .hlda(hlda), .dreq(dreq), .upd_valid(upd_valid), .upd_ch(upd_ch),
        .upd_addr(upd_addr), .upd_count(upd_count), .upd_tc(upd_tc),
        .temp_load(temp_load), .temp_in(temp_in),
        .cur_addr(cur_addr), .cur_count(cur_count), .base_addr(base_addr),
        .base_count(base_count), .mode(mode), .command(command), .mask(mask),
        .sw_req(sw_req)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [15:0] m_base_addr [4];
    logic [15:0] m_base_cnt  [4];
    logic [15:0] m_cur_addr  [4];
    logic [15:0] m_cur_cnt   [4];
    logic [7:0]  m_mode      [4];   // full written mode byte
    logic [7:0]  m_cmd, m_temp;
    logic [3:0]  m_mask, m_swreq, m_tc;
    logic        m_ff;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_base_addr[c] = 16'h0000; m_base_cnt[c] = 16'h0000;
            m_cur_addr[c]  = 16'h0000; m_cur_cnt[c]  = 16'h0000;
            m_mode[c]      = 8'h00;
        end
        m_cmd = 8'h00; m_temp = 8'h00; m_mask = 4'hF; m_swreq = 4'h0; m_tc = 4'h0; m_ff = 1'b0;
    endtask

    // One complete CPU write access (start effects, then end-of-access toggle).
    task automatic model_write(input logic [3:0] a, input logic [7:0] d);
        int ch;
        ch = int'(a) / 2;
        if (a < 4'd8) begin
            if (a[0]) begin
                if (m_ff) begin m_base_cnt[ch][15:8] = d; m_cur_cnt[ch][15:8] = d; end
                else      begin m_base_cnt[ch][7:0]  = d; m_cur_cnt[ch][7:0]  = d; end
            end else begin
                if (m_ff) begin m_base_addr[ch][15:8] = d; m_cur_addr[ch][15:8] = d; end
                else      begin m_base_addr[ch][7:0]  = d; m_cur_addr[ch][7:0]  = d; end
            end
            m_ff = ~m_ff;
        end else begin
            case (a)
                4'd8:  m_cmd = d;
                4'd9:  m_swreq[d[1:0]] = d[2];
                4'd10: m_mask[d[1:0]] = d[2];
                4'd11: m_mode[d[1:0]] = d;
                4'd12: m_ff = 1'b0;
                4'd13: begin m_cmd = 8'h00; m_swreq = 4'h0; m_tc = 4'h0; m_temp = 8'h00; m_ff = 1'b0; m_mask = 4'hF; end
                4'd14: m_mask = 4'h0;
                default: m_mask = d[3:0];
            endcase
        end
    endtask

    function automatic logic [7:0] model_read(input logic [3:0] a);
        logic [15:0] w;
        int ch;
        ch = int'(a) / 2;
        if (a < 4'd8) begin
            w = a[0] ? m_cur_cnt[ch] : m_cur_addr[ch];
            return m_ff ? w[15:8] : w[7:0];
        end else if (a == 4'd8) begin
            return {dreq | m_swreq, m_tc};
        end else if (a == 4'd13) begin
            return m_temp;
        end
        return 8'h00;
    endfunction

    task automatic model_engine(input int ch, input logic [15:0] ad, input logic [15:0] cnt, input logic tc);
        if (tc) begin
            m_tc[ch] = 1'b1;
            m_swreq[ch] = 1'b0;
            if (m_mode[ch][4]) begin
                m_cur_addr[ch] = m_base_addr[ch];
                m_cur_cnt[ch]  = m_base_cnt[ch];
            end else begin
                m_cur_addr[ch] = ad;
                m_cur_cnt[ch]  = cnt;
                m_mask[ch]     = 1'b1;
            end
        end else begin
            m_cur_addr[ch] = ad;
            m_cur_cnt[ch]  = cnt;
        end
    endtask

    task automatic check_all(input string tag);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("%s cur_addr%0d", tag, c),   32'(cur_addr[c]),   32'(m_cur_addr[c]));
            check($sformatf("%s cur_count%0d", tag, c),  32'(cur_count[c]),  32'(m_cur_cnt[c]));
            check($sformatf("%s base_addr%0d", tag, c),  32'(base_addr[c]),  32'(m_base_addr[c]));
            check($sformatf("%s base_count%0d", tag, c), 32'(base_count[c]), 32'(m_base_cnt[c]));
            check($sformatf("%s mode%0d", tag, c),       32'(mode[c]),       32'(m_mode[c][7:2]));
        end
        check({tag, " command"}, 32'(command), 32'(m_cmd));
        check({tag, " mask"},    32'(mask),    32'(m_mask));
        check({tag, " sw_req"},  32'(sw_req),  32'(m_swreq));
    endtask

    // All drive tasks are entered 1 time unit after a rising edge.
    task automatic cpu_write(input logic [3:0] a, input logic [7:0] d, input int hold);
        cs_n = 1'b0; iow_n = 1'b0; addr = a; data_in = d;
        repeat (hold) @(posedge clk);
        #1; cs_n = 1'b1; iow_n = 1'b1;
        @(posedge clk); #1;
        if (!hlda) model_write(a, d);
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [7:0] got);
        cs_n = 1'b0; ior_n = 1'b0; addr = a;
        #1;
        got = data_out;
        check("rd_data", 32'(data_out), hlda ? 32'h0 : 32'(model_read(a)));
        check("rd_oe",   32'(data_oe),  hlda ? 32'h0 : 32'h1);
        @(posedge clk); #1;
        cs_n = 1'b1; ior_n = 1'b1;
        @(posedge clk); #1;
        if (!hlda) begin
            if (a < 4'd8) m_ff = ~m_ff;
            if (a == 4'd8) m_tc = 4'h0;
        end
    endtask

    task automatic engine_update(input int ch, input logic [15:0] ad, input logic [15:0] cnt, input logic tc);
        upd_valid = 1'b1; upd_ch = 2'(ch); upd_addr = ad; upd_count = cnt; upd_tc = tc;
        @(posedge clk); #1;
        upd_valid = 1'b0; upd_tc = 1'b0;
        model_engine(ch, ad, cnt, tc);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] got;
        int op;
        logic [3:0] ra;
        logic [7:0] rd8;
        reset = 1'b1; cs_n = 1'b1; ior_n = 1'b1; iow_n = 1'b1; hlda = 1'b0;
        addr = 4'd0; data_in = 8'h00; dreq = 4'h0; upd_valid = 1'b0; upd_ch = 2'd0;
        upd_addr = 16'h0000; upd_count = 16'h0000; upd_tc = 1'b0; temp_load = 1'b0; temp_in = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1; reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        check("reset data_out", 32'(data_out), 32'h0);
        check("reset data_oe",  32'(data_oe),  32'h0);

        // Master clear then a two-byte address write and read-back
        cpu_write(4'd13, 8'h00, 1);
        cpu_write(4'd0, 8'h34, 1);
        cpu_write(4'd0, 8'h12, 1);
        check("ch0 base 1234", 32'(base_addr[0]), 32'h1234);
        check("ch0 cur 1234",  32'(cur_addr[0]),  32'h1234);
        check_all("two-byte");
        cpu_read(4'd0, got); check("rd lo 34", 32'(got), 32'h34);
        cpu_read(4'd0, got); check("rd hi 12", 32'(got), 32'h12);

        // Clear BPFF after a single byte
        cpu_write(4'd2, 8'h56, 1);
        cpu_write(4'd12, 8'h00, 1);
        cpu_write(4'd2, 8'h78, 1);
        check("clr bpff lo", 32'(cur_addr[1]), 32'h0078);
        cpu_write(4'd12, 8'h00, 1);

        // Autoinit terminal count on channel 1
        cpu_write(4'd11, 8'h55, 1);
        cpu_write(4'd3, 8'h10, 1);
        cpu_write(4'd3, 8'h00, 1);
        cpu_write(4'd14, 8'h00, 1);
        engine_update(1, 16'hBEEF, 16'h0003, 1'b1);
        check("autoinit count", 32'(cur_count[1]), 32'h0010);
        check("autoinit mask",  32'(mask[1]),      32'h0);
        check_all("autoinit");
        cpu_read(4'd8, got); check("status tc1 set", 32'(got[1]), 32'h1);
        cpu_read(4'd8, got); check("status tc1 clr", 32'(got[1]), 32'h0);

        // Terminal count without autoinit
        cpu_write(4'd11, 8'h45, 1);
        engine_update(1, 16'h2222, 16'h0007, 1'b1);
        check("no-ai mask",  32'(mask[1]),      32'h1);
        check("no-ai count", 32'(cur_count[1]), 32'h0007);

        // Software request and its clearing by terminal count
        cpu_write(4'd9, 8'h06, 1);
        check("sw_req2 set", 32'(sw_req[2]), 32'h1);
        cpu_read(4'd8, got); check("status req2", 32'(got[6]), 32'h1);
        engine_update(2, 16'h0100, 16'h0001, 1'b1);
        check("sw_req2 clr", 32'(sw_req[2]), 32'h0);
        check_all("swreq");

        // Long strobe: one write, one toggle
        cpu_write(4'd2, 8'h9A, 5);
        check("long wr", 32'(cur_addr[1]), 32'h229A);
        check_all("long");
        cpu_read(4'd2, got); check("long bpff", 32'(got), 32'h22);

        // Access while hlda is high is ignored
        hlda = 1'b1;
        cpu_write(4'd8, 8'hFF, 2);
        cpu_write(4'd1, 8'hEE, 1);
        cpu_read(4'd0, got);
        hlda = 1'b0;
        check_all("hlda");
        cpu_read(4'd0, got);

        // Engine update and CPU write to the same channel in one cycle
        cs_n = 1'b0; iow_n = 1'b0; addr = 4'd2; data_in = 8'hAB;
        upd_valid = 1'b1; upd_ch = 2'd1; upd_addr = 16'h4321; upd_count = 16'h0055; upd_tc = 1'b0;
        @(posedge clk); #1;
        upd_valid = 1'b0; cs_n = 1'b1; iow_n = 1'b1;
        @(posedge clk); #1;
        model_write(4'd2, 8'hAB);
        model_engine(1, 16'h4321, 16'h0055, 1'b0);
        check("engine wins", 32'(cur_addr[1]), 32'h4321);
        check_all("collide");

        // Terminal count coinciding with the status-read clear
        cs_n = 1'b0; ior_n = 1'b0; addr = 4'd8;
        @(posedge clk); #1;
        cs_n = 1'b1; ior_n = 1'b1;
        upd_valid = 1'b1; upd_ch = 2'd3; upd_addr = 16'h0001; upd_count = 16'h0002; upd_tc = 1'b1;
        @(posedge clk); #1;
        upd_valid = 1'b0; upd_tc = 1'b0;
        m_tc = 4'h0;
        model_engine(3, 16'h0001, 16'h0002, 1'b1);
        cpu_read(4'd8, got); check("tc set wins", 32'(got[3]), 32'h1);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            op = int'($urandom_range(0, 6));
            ra = 4'($urandom_range(0, 15));
            rd8 = 8'($urandom);
            case (op)
                0, 1: cpu_write(ra, rd8, int'($urandom_range(1, 3)));
                2:    cpu_read(ra, got);
                3:    engine_update(int'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                                    ($urandom_range(0, 2) == 0));
                4: begin
                    temp_load = 1'b1; temp_in = rd8;
                    @(posedge clk); #1;
                    temp_load = 1'b0; m_temp = rd8;
                end
                5: begin
                    dreq = 4'($urandom);
                    cpu_read(4'd8, got);
                end
                default: begin
                    hlda = 1'b1;
                    cpu_write(ra, rd8, 1);
                    hlda = 1'b0;
                end
            endcase
            check_all($sformatf("rand%0d", i));
        end

        // Reset in the middle of a write; strobe held low past reset
        cs_n = 1'b0; iow_n = 1'b0; addr = 4'd0; data_in = 8'h99; reset = 1'b1;
        repeat (2) @(posedge clk);
        #1; reset = 1'b0;
        repeat (2) @(posedge clk);
        #1; cs_n = 1'b1; iow_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        dreq = 4'h0;
        model_reset();
        check_all("mid reset");
        cpu_write(4'd0, 8'h11, 1);
        check("post reset lo", 32'(cur_addr[0]), 32'h0011);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dma_register_file.md
# dma_register_file

Program-mode register file of the 8237A DMA controller. It decodes CPU I/O reads and writes on the 4-bit register address space and owns all of the following:
- the byte-pointer flip-flop (BPFF)
- per-channel base/current address and word count
- mode, command, mask, request, status and temporary registers

It sits between the CPU bus interface and the priority/timing engine. It feeds the engine its configuration and absorbs the engine's per-transfer address/count updates and terminal-count events.

## Interface
Parameters:
- NCH, 4, channel count (fixed at 4 by the address map)
- AW, 16, address/word-count register width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cs_n  in  1  chip select, active low
- ior_n  in  1  I/O read strobe, active low
- iow_n  in  1  I/O write strobe, active low
- addr  in  4  register address, decoded with the shared address-code constants
- data_in  in  8  CPU write data
- data_out  out  8  CPU read data; 0 when no read is in progress
- data_oe  out  1  high while a read is in progress
- hlda  in  1  hold acknowledge; CPU accesses are honoured only while low
- dreq  in  4  hardware requests; these only feed the status register
- upd_valid  in  1  engine update strobe
- upd_ch  in  2  channel being updated
- upd_addr  in  16  new current address
- upd_count  in  16  new current word count
- upd_tc  in  1  the update reached terminal count
- temp_load, temp_in  in  1, 8  memory-to-memory temporary register load
- cur_addr, cur_count  out  [4][16]  current registers
- base_addr, base_count  out  [4][16]  base registers
- mode  out  [4][6]  mode bits 7:2 per channel
- command  out  8  command register
- mask  out  4  channel mask bits
- sw_req  out  4  software request bits

## Operation
An access is active when cs_n=0, hlda=0, and exactly one of ior_n/iow_n is low.
- **Access start** is the first active cycle. It is detected using a registered copy of the active term.
- **Access end** is the first inactive cycle after an active one.

Writes commit at access start:
- **Addresses 0–7:** write the selected byte into both the base and current register of the channel. BPFF=0 selects the low byte, BPFF=1 the high byte. BPFF toggles at access end.
- **8:** command ← data_in.
- **9:** sw_req[data_in[1:0]] ← data_in[2].
- **10:** mask[data_in[1:0]] ← data_in[2].
- **11:** mode[data_in[1:0]] ← data_in[7:2].
- **12:** BPFF ← 0.
- **13 (master clear):**
  - command, status, sw_req, temp and BPFF ← 0
  - mask ← 4'hF
- **14:** mask ← 0.
- **15:** mask ← data_in[3:0].

Reads:
- data_out is combinational from addr and BPFF.
- Addresses 0–7 return the current register byte; BPFF toggles at access end.
- **8:** status = {dreq | sw_req, tc_latch[3:0]}. tc_latch clears at access end.
- **13:** temporary register.
- Other read addresses return 8'h00.

Engine updates (upd_valid=1):
- current ← upd_addr/upd_count.
- If upd_tc:
  - tc_latch[ch] ← 1 and sw_req[ch] ← 0.
  - If mode[ch][2] (autoinit, bit 4 of the written byte), current ← base instead.
  - Otherwise mask[ch] ← 1.

## Timing
- Reset (synchronous) values:
  - all address/count registers 0
  - mode 0, command 0, sw_req 0, tc_latch 0, temp 0
  - BPFF 0
  - mask 4'hF
  - data_out 0, data_oe 0
- Register outputs are valid the cycle after the committing edge.
- A strobe held low for many cycles performs exactly one write and one BPFF toggle.
- Simultaneous events:
  - A CPU access while hlda=1 is ignored entirely.
  - An engine update and a CPU write to the same channel register in the same cycle: the engine update wins.
  - A TC set coinciding with the status-read clear: the set wins.
- 16-bit registers never wrap here; arithmetic belongs to the engine.
- Reset mid-access aborts the access. The strobe must return high before a new access starts.

## Structure
- Address codes come from the existing DmaRegisterAddressCode package.
- Add to that package or a companion package:
  - a mode_t packed struct {transfer_mode[1:0], addr_dec, autoinit, xfer_type[1:0]}
  - status bit-position constants
- One sub-module, dma_channel_regs, instantiated NCH times. It holds the base/current address and count for one channel, with byte-write, engine-update and autoinit-reload logic.

## Test plan
- Master clear, then write 0x34 and then 0x12 to address 0 → base_addr[0]=cur_addr[0]=16'h1234. Two reads of address 0 return 0x34 then 0x12.
- Write 0x00 to address 12 mid-sequence after a single byte write → the next write lands in the low byte again.
- Mode ch1 = 0x55 (autoinit) with base count 0x0010, then an engine update with upd_tc=1 → cur_count[1]=0x0010, mask[1] stays 0, and status bit 1 set. A status read returns bit 1 set, and the next status read shows it cleared.
- Same scenario without autoinit → mask[1]=1 and cur_count[1]=upd_count.
- Write 0x06 to address 9 → sw_req[2]=1 and status bit 6=1. A TC on ch2 clears sw_req[2].
- Hold iow_n low for 5 cycles on address 2 → one byte written, BPFF toggles once. An access with hlda=1 → no register change.
